booth_mul: RTL and testbench



---
 rtl/booth_mul.sv | 137 +++++++++++++
 tb/tb_booth_mul.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul.sv
// booth_mul: iterative radix-4 Booth multiplier for the RV32M MUL/MULH/MULHSU/MULHU group.
// Uses the same start/busy/done handshake as the iterative divider.
// Optional build macro MUL_ZERO_BYPASS_EN: a zero operand skips INIT/COMPUTE and
// completes through FINISH with a zero product.
module booth_mul #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] multiplicand,
  input  logic [XLEN-1:0] multiplier,
  input  logic [1:0]      op,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int ACCW = 2 * XLEN + 4;
  localparam int ITER = (XLEN + 2) / 2;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    INIT    = 2'b01,
    COMPUTE = 2'b10,
    FINISH  = 2'b11
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [1:0]        op_q;
  logic [ACCW-1:0]   acc;
  logic [ACCW-1:0]   mcand_sh;
  logic [XLEN+2:0]   mplr_sh;
  logic [CW-1:0]     count;

  logic              a_signed;
  logic              b_signed;
  logic [ACCW-1:0]   mcand_init;
  logic [XLEN+2:0]   mplr_init;
  logic [ACCW-1:0]   acc_next;

  // Multiplicand is signed for MULH/MULHSU, multiplier only for MULH; the multiplier
  // carries two extra sign bits plus the implicit zero below its LSB.
  always_comb begin
    a_signed   = (op_q == OP_MULH) || (op_q == OP_MULHSU);
    b_signed   = (op_q == OP_MULH);
    mcand_init = {{(ACCW-XLEN){a_signed & a_q[XLEN-1]}}, a_q};
    mplr_init  = {{2{b_signed & b_q[XLEN-1]}}, b_q, 1'b0};
  end

  // Booth recoding of the current 3-bit window; the multiplicand is already shifted to weight 4^count.
  always_comb begin
    acc_next = acc;
    case (mplr_sh[2:0])
      3'b001, 3'b010: acc_next = acc + mcand_sh;
      3'b011:         acc_next = acc + (mcand_sh << 1);
      3'b100:         acc_next = acc - (mcand_sh << 1);
      3'b101, 3'b110: acc_next = acc - mcand_sh;
      default:        acc_next = acc;
    endcase
  end

  // Control FSM and datapath registers; outputs are registered and done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      acc      <= '0;
      mcand_sh <= '0;
      mplr_sh  <= '0;
      count    <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= multiplicand;
            b_q  <= multiplier;
            op_q <= op;
            busy <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
            if ((multiplicand == '0) || (multiplier == '0)) begin
              acc   <= '0;
              state <= FINISH;
            end else begin
              state <= INIT;
            end
`else
            state <= INIT;
`endif
          end
        end
        INIT: begin
          mcand_sh <= mcand_init;
          mplr_sh  <= mplr_init;
          acc      <= '0;
          count    <= '0;
          state    <= COMPUTE;
        end
        COMPUTE: begin
          acc      <= acc_next;
          mcand_sh <= mcand_sh << 2;
          mplr_sh  <= {{2{mplr_sh[XLEN+2]}}, mplr_sh[XLEN+2:2]};
          if (count == LAST_COUNT) begin
            state <= FINISH;
          end else begin
            count <= count + 1'b1;
          end
        end
        FINISH: begin
          result <= (op_q == OP_MUL) ? acc[XLEN-1:0] : acc[2*XLEN-1:XLEN];
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul.sv
// tb_booth_mul: self-checking bench for booth_mul (directed cases plus randomized
// operations against a 64-bit arithmetic reference model).
module tb_booth_mul;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [1:0]  op;
  logic [31:0] result;
  logic        busy;
  logic        done;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNum    = 0;
  int t0          = 0;

  booth_mul #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .op           (op),
    .result       (result),
    .busy         (busy),
    .done         (done)
  );

  // Free-running clock and cycle counter used to measure latency
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  // Hard time limit so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no end of test, expected completion before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference product: widen each operand to 64 bits by the op's signedness and multiply
  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    longint sa;
    longint sb;
    longint p;
    sa = ((o == OP_MULH) || (o == OP_MULHSU)) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (o == OP_MULH) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = sa * sb;
    return (o == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int expLat(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if ((a == 32'd0) || (b == 32'd0)) return 2;
`endif
    return 20;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one request so it is sampled at the next edge, then scramble the inputs
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    multiplicand = a;
    multiplier   = b;
    op           = o;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start        = 1'b0;
    t0           = cycleNum - 1;
    multiplicand = $urandom;
    multiplier   = $urandom;
    op           = 2'($urandom_range(0, 3));
  endtask

  // Follow the operation up to its expected done cycle, checking busy and done every cycle
  task automatic waitDone(input string tag, input int lat, input logic [31:0] expRes);
    int rel;
    int firstDone;
    int doneCnt;
    int busyBad;
    firstDone = -1;
    doneCnt   = 0;
    busyBad   = 0;
    rel       = cycleNum - t0;
    while (rel <= lat) begin
      if (done) begin
        doneCnt++;
        if (firstDone < 0) firstDone = rel;
      end
      if (busy !== (rel < lat)) busyBad++;
      if (rel == lat) break;
      @(posedge clk);
      #1;
      rel = cycleNum - t0;
    end
    checkOutput({tag, " done cycle"}, firstDone, lat);
    checkOutput({tag, " done count"}, doneCnt, 1);
    checkOutput({tag, " busy profile"}, busyBad, 0);
    checkOutput({tag, " result"}, result, expRes);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic [31:0] exp;
    string       tag;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;

    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    op           = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset result", result, 0);

    $display("[TB] start with reset asserted");
    applyStimulus(32'd3, 32'd5, OP_MUL);
    checkOutput("reset-wins busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset-wins stays idle", busy, 0);

    $display("[TB] directed operations");
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHU,  32'hFFFF_FFFE, "mulhu ff*ff"});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MUL,    32'h0000_0001, "mul ff*ff"});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, OP_MULH,   32'h4000_0000, "mulh min*min"});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, OP_MUL,    32'h0000_0000, "mul min*min"});
    vecs.push_back('{32'hFFFF_FFFE, 32'h0000_0003, OP_MULH,   32'hFFFF_FFFF, "mulh -2*3"});
    vecs.push_back('{32'hFFFF_FFFE, 32'h0000_0003, OP_MUL,    32'hFFFF_FFFA, "mul -2*3"});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHSU, 32'hFFFF_FFFF, "mulhsu -1*ff"});
    vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_MULHSU, 32'h7FFF_FFFE, "mulhsu max*ff"});
    vecs.push_back('{32'h7FFF_FFFF, 32'hFFFF_FFFF, OP_MULHU,  32'h7FFF_FFFE, "mulhu max*ff"});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].o);
      waitDone(vecs[i].tag, 20, vecs[i].exp);
    end

    $display("[TB] start while busy is ignored");
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(32'd3, 32'd5, OP_MUL);
    repeat (7) @(posedge clk);
    #1;
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    op           = OP_MULHU;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("busy-start", 20, 32'h0000_000F);
    applyStimulus(32'd7, 32'd6, OP_MUL);
    waitDone("start-on-done", 20, 32'h0000_002A);

    $display("[TB] reset mid-operation");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, OP_MULHU);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort result", result, 0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) cnt++;
      @(posedge clk);
      #1;
    end
    checkOutput("abort no done", cnt, 0);
    applyStimulus(32'h0001_0000, 32'h0001_0000, OP_MUL);
    waitDone("post-reset mul", 20, 32'h0000_0000);
    applyStimulus(32'h0001_0000, 32'h0001_0000, OP_MULHU);
    waitDone("post-reset mulhu", 20, 32'h0000_0001);

    $display("[TB] zero operand");
    applyStimulus(32'h0000_0000, 32'h1234_5678, OP_MUL);
    waitDone("zero mul", expLat(32'h0000_0000, 32'h1234_5678), 32'h0000_0000);
    applyStimulus(32'hDEAD_BEEF, 32'h0000_0000, OP_MULH);
    waitDone("zero mulh", expLat(32'hDEAD_BEEF, 32'h0000_0000), 32'h0000_0000);

    $display("[TB] randomized operations");
    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      rb = $urandom;
      ro = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      if ($urandom_range(0, 3) == 0) ra = {ra[31], 31'h0} | 32'h1;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      applyStimulus(ra, rb, ro);
      waitDone($sformatf("rand%0d op%0d", n, ro), expLat(ra, rb), refMul(ra, rb, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
